// File: rtl/nor_gate.sv
// rtl/nor_gate.sv - registered, width-scalable bitwise NOR with valid-qualified fixed-latency pipeline
// Optional feature macro: NOR_GATE_TOGGLE_CNT_EN (result-change counter on toggle_cnt).
module nor_gate #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] F,
  output logic             F_all,
  output logic             out_valid,
  output logic [15:0]      toggle_cnt
);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("nor_gate: WIDTH must be in 1..64");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
      $error("nor_gate: PIPE_STAGES must be in 1..4");
    end
  endgenerate

  // Per-lane NOR and the all-lanes-true reduction of the same sample.
  logic [WIDTH-1:0] r;
  logic             r_all;

  assign r     = ~(A | B);
  assign r_all = &r;

  // src_* is what feeds stage k: the fresh result for stage 0, the previous stage otherwise.
  logic [WIDTH-1:0] src_data [PIPE_STAGES];
  logic             src_all  [PIPE_STAGES];
  logic             src_vld  [PIPE_STAGES];

  logic [WIDTH-1:0] data_q [PIPE_STAGES];
  logic             all_q  [PIPE_STAGES];
  logic             vld_q  [PIPE_STAGES];

  // Route each stage's input: stage 0 from the NOR logic, later stages from their predecessor.
  always_comb begin
    src_data[0] = r;
    src_all[0]  = r_all;
    src_vld[0]  = in_valid;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      src_data[k] = data_q[k-1];
      src_all[k]  = all_q[k-1];
      src_vld[k]  = vld_q[k-1];
    end
  end

  // Valid shifts every cycle; data only loads behind a valid so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k] <= '0;
        all_q[k]  <= 1'b0;
        vld_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        vld_q[k] <= src_vld[k];
        if (src_vld[k]) begin
          data_q[k] <= src_data[k];
          all_q[k]  <= src_all[k];
        end
      end
    end
  end

  assign F         = data_q[PIPE_STAGES-1];
  assign F_all     = all_q[PIPE_STAGES-1];
  assign out_valid = vld_q[PIPE_STAGES-1];

`ifdef NOR_GATE_TOGGLE_CNT_EN
  logic [15:0] cnt_q;

  // Count output-stage loads whose result differs from the value F held before the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (src_vld[PIPE_STAGES-1] && (src_data[PIPE_STAGES-1] != data_q[PIPE_STAGES-1])) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign toggle_cnt = cnt_q;
`else
  assign toggle_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_nor_gate.sv
// tb/tb_nor_gate.sv - self-checking bench for nor_gate across three width/latency configurations
module tb_nor_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a0, b0, v0;
  logic [7:0] a1, b1, a2, b2;
  logic       v1, v2;

  logic        f0, fa0, ov0;
  logic [7:0]  f1, f2;
  logic        fa1, ov1, fa2, ov2;
  logic [15:0] tc0, tc1, tc2;

  nor_gate #(.WIDTH(1), .PIPE_STAGES(1)) u_w1_p1 (
    .clk(clk), .rst(rst), .A(a0), .B(b0), .in_valid(v0),
    .F(f0), .F_all(fa0), .out_valid(ov0), .toggle_cnt(tc0)
  );

  nor_gate #(.WIDTH(8), .PIPE_STAGES(3)) u_w8_p3 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(v1),
    .F(f1), .F_all(fa1), .out_valid(ov1), .toggle_cnt(tc1)
  );

  nor_gate #(.WIDTH(8), .PIPE_STAGES(2)) u_w8_p2 (
    .clk(clk), .rst(rst), .A(a2), .B(b2), .in_valid(v2),
    .F(f2), .F_all(fa2), .out_valid(ov2), .toggle_cnt(tc2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  function automatic int lat(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input int i);
    return (i == 0) ? 8'h01 : 8'hFF;
  endfunction

  // Model: a sample accepted at edge s is the output after edge s+lat-1,
  // unless a reset edge happened at or after s.
  logic        hv [3][4096];
  logic [7:0]  hd [3][4096];
  int          e = 0;
  int          last_rst = -1;
  bit          started = 1'b0;
  logic        exp_v [3];
  logic [7:0]  exp_f [3];
  logic [15:0] exp_c [3];
  logic [7:0]  m_a, m_b;
  logic        m_v;
  int          m_s;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin m_a = {7'b0, a0}; m_b = {7'b0, b0}; m_v = v0; end
        1:       begin m_a = a1; m_b = b1; m_v = v1; end
        default: begin m_a = a2; m_b = b2; m_v = v2; end
      endcase
      hv[i][e] = (m_v === 1'b1) && (rst !== 1'b1);
      hd[i][e] = ~(m_a | m_b) & lane_mask(i);
    end
    if (rst === 1'b1) begin
      last_rst = e;
      started  = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      m_s = e - lat(i) + 1;
      if (rst === 1'b1) begin
        exp_v[i] = 1'b0;
        exp_f[i] = 8'h00;
        exp_c[i] = 16'd0;
      end else if (m_s >= 0 && m_s > last_rst && hv[i][m_s]) begin
        exp_v[i] = 1'b1;
        if (hd[i][m_s] != exp_f[i]) exp_c[i] = exp_c[i] + 16'd1;
        exp_f[i] = hd[i][m_s];
      end else begin
        exp_v[i] = 1'b0;
      end
    end
    e++;
  end

  logic [7:0]  c_f;
  logic        c_fa, c_ov;
  logic [15:0] c_tc, c_want_tc;

  // Compare every instance against the model on the falling edge of each cycle after reset.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       begin c_f = {7'b0, f0}; c_fa = fa0; c_ov = ov0; c_tc = tc0; end
          1:       begin c_f = f1; c_fa = fa1; c_ov = ov1; c_tc = tc1; end
          default: begin c_f = f2; c_fa = fa2; c_ov = ov2; c_tc = tc2; end
        endcase
`ifdef NOR_GATE_TOGGLE_CNT_EN
        c_want_tc = exp_c[i];
`else
        c_want_tc = 16'd0;
`endif
        chk("out_valid", i, {15'b0, c_ov}, {15'b0, exp_v[i]});
        chk("F", i, {8'b0, c_f}, {8'b0, exp_f[i]});
        chk("F_all", i, {15'b0, c_fa}, {15'b0, (exp_f[i] == lane_mask(i))});
        chk("toggle_cnt", i, c_tc, c_want_tc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  vec_ab [4];
  logic        vec_f  [4];
  logic [15:0] tc_base;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_ab[0] = 2'b00; vec_ab[1] = 2'b01; vec_ab[2] = 2'b10; vec_ab[3] = 2'b11;
    vec_f[0]  = 1'b1;  vec_f[1]  = 1'b0;  vec_f[2]  = 1'b0;  vec_f[3]  = 1'b0;

    rst = 1'b1;
    a0 = 1'b0; b0 = 1'b0; v0 = 1'b0;
    a1 = 8'h00; b1 = 8'h00; v1 = 1'b0;
    a2 = 8'h00; b2 = 8'h00; v2 = 1'b0;
    tick();
    tick();
    chk("lit_reset_F", 0, {15'b0, f0}, 16'd0);
    chk("lit_reset_ov", 1, {15'b0, ov1}, 16'd0);

    // Truth table on the 1-bit, 1-cycle instance, each vector held 100 ns.
    rst = 1'b0;
    v0  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      {a0, b0} = vec_ab[j];
      tick();
      chk("lit_tt_F", j, {15'b0, f0}, {15'b0, vec_f[j]});
      chk("lit_tt_ov", j, {15'b0, ov0}, 16'd1);
      for (int k = 0; k < 9; k++) tick();
    end

    // Reset held two cycles with a valid (0,0) driven; rst must win.
    a0 = 1'b0; b0 = 1'b0;
    rst = 1'b1;
    tick();
    chk("lit_rst_F", 0, {15'b0, f0}, 16'd0);
    tick();
    chk("lit_rst_ov", 0, {15'b0, ov0}, 16'd0);
    rst = 1'b0;
    tick();
    chk("lit_post_rst_F", 0, {15'b0, f0}, 16'd1);

    // Three-stage latency on the 8-bit instance.
    a1 = 8'h0F; b1 = 8'h30; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    chk("lit_p3_early_ov", 1, {15'b0, ov1}, 16'd0);
    tick();
    chk("lit_p3_F", 1, {8'b0, f1}, 16'h00C0);
    chk("lit_p3_Fall", 1, {15'b0, fa1}, 16'd0);
    a1 = 8'h00; b1 = 8'h00; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    tick();
    chk("lit_p3_F2", 1, {8'b0, f1}, 16'h00FF);
    chk("lit_p3_Fall2", 1, {15'b0, fa1}, 16'd1);

    // Bubble pattern 1,0,1 on the two-stage instance.
    b2 = 8'h00;
    a2 = 8'hAA; v2 = 1'b1;
    tick();
    a2 = 8'h55; v2 = 1'b0;
    tick();
    chk("lit_p2_ov1", 2, {15'b0, ov2}, 16'd1);
    chk("lit_p2_F1", 2, {8'b0, f2}, 16'h0055);
    a2 = 8'h00; v2 = 1'b1;
    tick();
    chk("lit_p2_ov2", 2, {15'b0, ov2}, 16'd0);
    chk("lit_p2_hold", 2, {8'b0, f2}, 16'h0055);
    v2 = 1'b0;
    tick();
    chk("lit_p2_F3", 2, {8'b0, f2}, 16'h00FF);

    // Unknown operands with no valid must leave F untouched.
    a2 = 8'hxx; b2 = 8'hxx;
    tick();
    tick();
    chk("lit_x_hold", 2, {8'b0, f2}, 16'h00FF);
    a2 = 8'h00; b2 = 8'h00;

    // Two samples in flight then a one-cycle reset: neither may emerge.
    a1 = 8'h01; b1 = 8'h00; v1 = 1'b1;
    tick();
    a1 = 8'h02;
    tick();
    v1 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lit_flush_ov", k, {15'b0, ov1}, 16'd0);
    end

    // Four-vector sequence twice starting from F=1: three result changes.
    a0 = 1'b0; b0 = 1'b0; v0 = 1'b1;
    tick();
    tc_base = tc0;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) begin
        {a0, b0} = vec_ab[j];
        tick();
      end
    end
`ifdef NOR_GATE_TOGGLE_CNT_EN
    chk("lit_toggle_delta", 0, tc0 - tc_base, 16'd3);
`else
    chk("lit_toggle_zero", 0, tc0, 16'd0);
`endif
    v0 = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nor_gate.md
Name: nor_gate

Overview:
- Registered, parameterizable bitwise two-operand NOR unit.
- Each output bit is F[i] = ~(A[i] | B[i]), delivered through a fixed-latency pipeline with a valid qualifier.
- Also produces a whole-vector "all lanes true" flag.
- Used as a leaf logic primitive wherever a clocked, width-scalable NOR with known latency is needed. The default configuration is a 1-bit, 1-cycle NOR gate.

Parameters:
- WIDTH, 1: lane count (bit width of A, B, F); legal range 1..64.
- PIPE_STAGES, 1: input-to-output latency in clock cycles; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  A/B are valid this cycle.
- F  output  WIDTH  registered bitwise NOR result.
- F_all  output  1  registered AND-reduction of the result lanes, equal to ~|(A|B) for the same sample.
- out_valid  output  1  F/F_all carry a newly valid result this cycle.
- toggle_cnt  output  16  count of result changes; meaningful only with the optional feature.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst: sampled only on the rising edge of clk.
- Reset values: all pipeline data registers, F, F_all and toggle_cnt = 0; every valid register and out_valid = 0.
  - F resets to 0 even though NOR(0,0)=1; reset values are not computed results.
- Computation:
  - Each lane is independent: r[i] = ~(A[i] | B[i]).
  - r_all = &r. No arithmetic or carry between lanes.
- Pipeline shape: PIPE_STAGES register stages. Stage 1 captures the computed r/r_all; later stages forward them unchanged. F, F_all and out_valid are the last stage (no combinational path from inputs to outputs).
- Latency: a sample with in_valid=1 at edge n appears on F/F_all with out_valid=1 after edge n+PIPE_STAGES-1, i.e. visible during cycle n+PIPE_STAGES.
- Valid shifting: the valid bit shifts through every stage every cycle, unconditionally.
- Data loading: a stage's data loads only when its incoming valid is 1. Otherwise it holds.
  - F/F_all therefore hold the last valid result while out_valid=0.
- in_valid=0 is a bubble: nothing is computed or loaded for it and it produces out_valid=0 at the output.
- Back-to-back valid inputs give back-to-back valid outputs at full throughput (one result per cycle). There is no backpressure and no stall.
- Reset mid-operation: all in-flight samples are discarded. out_valid stays 0 until a new valid sample completes the full latency after rst deasserts.
- Simultaneous rst and in_valid at the same edge: rst wins; the sample is dropped.
- X on A/B with in_valid=0 must not disturb F.
- Parameters outside their legal ranges: elaboration error via generate-time check.

Optional Feature:
- Macro: NOR_GATE_TOGGLE_CNT_EN.
- Defined:
  - toggle_cnt increments by 1 on each edge where the output stage loads a valid result whose F differs from the F value held before that load.
  - Wraps 0xFFFF -> 0x0000.
  - Cleared by rst.
- Undefined: no counter logic is built and toggle_cnt is tied to 0.

Test Plan:
- Defaults (WIDTH=1, PIPE_STAGES=1), in_valid=1, apply (A,B) = (0,0), (0,1), (1,0), (1,1), each held 100 ns -> F = 1, 0, 0, 0 respectively, one cycle after each change. F_all tracks F. out_valid stays 1.
- Assert rst for 2 cycles while driving A=0, B=0, in_valid=1 -> F=0, F_all=0, out_valid=0 during reset. F=1 one cycle after rst deasserts.
- WIDTH=8, PIPE_STAGES=3, A=0x0F, B=0x30 -> F=0xC0, F_all=0, out_valid=1 exactly 3 cycles later. Then A=0x00, B=0x00 -> F=0xFF, F_all=1.
- WIDTH=8, PIPE_STAGES=2, valid pattern 1,0,1 with A=0xAA/0x55/0x00 (B=0) -> out_valid pattern 1,0,1 delayed by 2 cycles. F = 0x55, then held at 0x55, then 0xFF.
- PIPE_STAGES=3, two valid samples in flight, then pulse rst for 1 cycle -> neither sample emerges; out_valid stays 0.
- With NOR_GATE_TOGGLE_CNT_EN, WIDTH=1, apply the four-vector sequence twice -> toggle_cnt=3 (1->0, 0->1, 1->0). Without the macro, toggle_cnt=0 throughout.
